// File: rtl/mag_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mag_pkg
// Brief    : Shared constants and result record for the magnitude stats path.
// Revision : 1.0
// ============================================================================
package mag_pkg;

  localparam int MAG_WIDTH        = 8;
  localparam int WIN_LOG2_DEFAULT = 3;

  typedef struct packed {
    logic [MAG_WIDTH-1:0] mean;
    logic [MAG_WIDTH-1:0] max;
    logic [MAG_WIDTH-1:0] min;
  } mag_stats_t;

endpackage
`default_nettype wire

// File: rtl/mag_minmax.sv
`default_nettype none
// ============================================================================
// Module   : mag_minmax
// Brief    : Next running max/min; the first sample of a window replaces both.
// Revision : 1.0
// ============================================================================
module mag_minmax
  import mag_pkg::*;
#(
  parameter int WIDTH = MAG_WIDTH
) (
  input  logic [WIDTH-1:0] run_max,
  input  logic [WIDTH-1:0] run_min,
  input  logic [WIDTH-1:0] sample,
  input  logic             first,
  output logic [WIDTH-1:0] max_next,
  output logic [WIDTH-1:0] min_next
);

  always_comb begin
    max_next = run_max;
    min_next = run_min;
    if (first) begin
      max_next = sample;
      min_next = sample;
    end else begin
      if (sample > run_max) max_next = sample;
      if (sample < run_min) min_next = sample;
    end
  end

endmodule
`default_nettype wire

// File: rtl/magnitude_window_stats.sv
`default_nettype none
// ============================================================================
// Module   : magnitude_window_stats
// Brief    : Mean/max/min over fixed windows of 2^LOG2_N magnitude samples.
// Revision : 1.0
// ============================================================================
module magnitude_window_stats
  import mag_pkg::*;
#(
  parameter int WIDTH  = MAG_WIDTH,
  parameter int LOG2_N = WIN_LOG2_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_mag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_mean,
  output logic [WIDTH-1:0] out_max,
  output logic [WIDTH-1:0] out_min
);

  localparam int ACC_W = WIDTH + LOG2_N;

  logic [LOG2_N-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [WIDTH-1:0]  run_max_q, run_max_d;
  logic [WIDTH-1:0]  run_min_q, run_min_d;
  mag_stats_t        out_q, out_d;
  logic              out_valid_q, out_valid_d;

  logic              first_w, last_w, in_ready_w, accept_w;
  logic [ACC_W-1:0]  sum_w;
  logic [WIDTH-1:0]  mean_w, max_next_w, min_next_w;

  assign first_w    = (cnt_q == '0);
  assign last_w     = &cnt_q;
  // Only the window-completing sample must wait for the output slot.
  assign in_ready_w = !flush && !(last_w && out_valid_q && !out_ready);
  assign accept_w   = in_valid && in_ready_w;
  assign sum_w      = (first_w ? '0 : acc_q) + ACC_W'(in_mag);
  assign mean_w     = sum_w[ACC_W-1:LOG2_N];

  mag_minmax #(
    .WIDTH (WIDTH)
  ) u_minmax (
    .run_max  (run_max_q),
    .run_min  (run_min_q),
    .sample   (in_mag),
    .first    (first_w),
    .max_next (max_next_w),
    .min_next (min_next_w)
  );

  always_comb begin
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    run_max_d   = run_max_q;
    run_min_d   = run_min_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    if (flush) begin
      cnt_d     = '0;
      acc_d     = '0;
      run_max_d = '0;
      run_min_d = '1;
    end else if (accept_w) begin
      acc_d     = sum_w;
      run_max_d = max_next_w;
      run_min_d = min_next_w;
      if (last_w) begin
        cnt_d       = '0;
        out_valid_d = 1'b1;
        out_d.mean  = MAG_WIDTH'(mean_w);
        out_d.max   = MAG_WIDTH'(max_next_w);
        out_d.min   = MAG_WIDTH'(min_next_w);
      end else begin
        cnt_d = cnt_q + LOG2_N'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      acc_q       <= '0;
      run_max_q   <= '0;
      run_min_q   <= '1;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      run_max_q   <= run_max_d;
      run_min_q   <= run_min_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Result fields are MAG_WIDTH wide; WIDTH is expected not to exceed it.
  assign in_ready  = in_ready_w;
  assign out_valid = out_valid_q;
  assign out_mean  = out_q.mean[WIDTH-1:0];
  assign out_max   = out_q.max[WIDTH-1:0];
  assign out_min   = out_q.min[WIDTH-1:0];

endmodule
`default_nettype wire

// File: tb/tb_magnitude_window_stats.sv
`default_nettype none
// ============================================================================
// Module   : tb_magnitude_window_stats
// Brief    : Scoreboard bench for magnitude_window_stats (WIDTH=8, LOG2_N=3).
// Revision : 1.0
// ============================================================================
module tb_magnitude_window_stats;

  logic       clk = 1'b0;
  logic       rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [7:0] in_mag, out_mean, out_max, out_min;

  magnitude_window_stats #(.WIDTH(8), .LOG2_N(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mag    (in_mag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_mean  (out_mean),
    .out_max   (out_max),
    .out_min   (out_min)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] mean;
    logic [7:0] max;
    logic [7:0] min;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic model_en = 1'b0;
  logic rand_en  = 1'b0;
  int   m_cnt, m_acc, m_max, m_min;
  int   n_acc = 0;

  task automatic expect_res(input int m, input int mx, input int mn);
    exp_t e;
    e.mean = 8'(m);
    e.max  = 8'(mx);
    e.min  = 8'(mn);
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Offer one sample and hold it until accepted; ends 1 time unit after the accepting edge.
  task automatic send(input int m);
    int guard = 0;
    in_valid = 1'b1;
    in_mag   = 8'(m);
    forever begin
      @(negedge clk);
      if (in_ready) break;
      guard++;
      if (guard > 200) begin
        n_tests++;
        n_fail++;
        $display("FAIL send_timeout: got in_ready=0 for %0d cycles, expected acceptance", guard);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Monitor: every result the consumer takes must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_result: got %0d/%0d/%0d, expected no result",
                 out_mean, out_max, out_min);
      end else begin
        mon_e = exp_q.pop_front();
        if (out_mean !== mon_e.mean || out_max !== mon_e.max || out_min !== mon_e.min) begin
          n_fail++;
          $display("FAIL result: got mean/max/min %0d/%0d/%0d, expected %0d/%0d/%0d",
                   out_mean, out_max, out_min, mon_e.mean, mon_e.max, mon_e.min);
        end
      end
    end
  end

  // Reference model for the randomized phase, fed by the samples actually offered.
  always @(negedge clk) begin
    if (model_en && !rst && in_valid && in_ready) begin
      n_acc++;
      if (m_cnt == 0) begin
        m_acc = int'(in_mag);
        m_max = int'(in_mag);
        m_min = int'(in_mag);
      end else begin
        m_acc += int'(in_mag);
        if (int'(in_mag) > m_max) m_max = int'(in_mag);
        if (int'(in_mag) < m_min) m_min = int'(in_mag);
      end
      if (m_cnt == 7) begin
        expect_res(m_acc / 8, m_max, m_min);
        m_cnt = 0;
      end else begin
        m_cnt++;
      end
    end
  end

  always @(posedge clk) begin
    if (rand_en) begin
      #1;
      out_ready = 1'($urandom % 2);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion, expected bench to finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int guard;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_mag = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_in_ready",  in_ready,  1);
    check("reset_out_valid", out_valid, 0);
    check("reset_out_mean",  out_mean,  0);
    check("reset_out_max",   out_max,   0);
    check("reset_out_min",   out_min,   0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Samples 1..8 back to back.
    expect_res(4, 8, 1);
    for (int i = 1; i <= 8; i++) send(i);
    check("latency_out_valid", out_valid, 1);
    repeat (2) @(posedge clk); #1;
    check("drained_out_valid", out_valid, 0);

    // All-255 window must not overflow.
    expect_res(255, 255, 255);
    for (int i = 0; i < 8; i++) send(255);
    repeat (2) @(posedge clk); #1;

    // Backpressure: second window completes only when the first drains.
    out_ready = 1'b0;
    expect_res(45, 80, 10);
    expect_res(125, 160, 90);
    for (int i = 1; i <= 15; i++) send(i * 10);
    in_valid = 1'b1; in_mag = 8'd160;
    @(negedge clk);
    check("stall_in_ready", in_ready, 0);
    check("held_out_valid", out_valid, 1);
    check("held_out_mean", out_mean, 45);
    check("held_out_max",  out_max,  80);
    check("held_out_min",  out_min,  10);
    @(posedge clk); #1;
    @(negedge clk);
    check("stall2_in_ready", in_ready, 0);
    check("held2_out_mean", out_mean, 45);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("release_in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("swap_out_valid", out_valid, 1);
    check("swap_out_mean", out_mean, 125);
    repeat (2) @(posedge clk); #1;

    // Flush drops the partial window and the sample offered alongside it.
    expect_res(3, 9, 3);
    for (int i = 0; i < 5; i++) send(100);
    flush = 1'b1; in_valid = 1'b1; in_mag = 8'd7;
    @(negedge clk);
    check("flush_in_ready", in_ready, 0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 7; i++) send(3);
    send(9);
    repeat (2) @(posedge clk); #1;

    // Reset mid-window with a result pending: that result is lost.
    out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) send(i);
    for (int i = 0; i < 4; i++) send(5);
    #1 rst = 1'b1;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_out_mean",  out_mean,  0);
    check("arst_out_max",   out_max,   0);
    check("arst_out_min",   out_min,   0);
    check("arst_in_ready",  in_ready,  1);
    @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b1;
    expect_res(2, 2, 2);
    for (int i = 0; i < 8; i++) send(2);
    repeat (2) @(posedge clk); #1;

    // Random valid/ready traffic against the reference model.
    m_cnt = 0;
    model_en = 1'b1;
    rand_en  = 1'b1;
    guard = 0;
    while (n_acc < 1000 && guard < 20000) begin
      in_valid = ($urandom % 4) != 0;
      in_mag   = 8'($urandom);
      @(posedge clk); #1;
      guard++;
    end
    in_valid = 1'b0;
    if (guard >= 20000) begin
      n_tests++;
      n_fail++;
      $display("FAIL random_timeout: got %0d accepted samples, expected 1000", n_acc);
    end
    rand_en = 1'b0;
    @(posedge clk); #2;
    out_ready = 1'b1;
    model_en  = 1'b0;
    repeat (10) @(posedge clk); #1;
    check("queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
